// File: rtl/ej32_pkg.sv
// rtl/ej32_pkg.sv - shared ej32 state type, step count and `DU data width
`ifndef EJ32_DU_DEFINED
`define EJ32_DU_DEFINED
`define DU [31:0]
`endif

package ej32_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX} div_state_t;
  localparam int DIV_STEPS = 32;
endpackage

// File: rtl/ej32_div.sv
// rtl/ej32_div.sv - signed 32-bit restoring divider with Java idiv/irem semantics
// EJ32_DIV_ZERO_CHK_EN: trap a zero divisor at start (1-cycle busy, div_by0 set)
module ej32_div
  import ej32_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     div_en,
  input  logic     op_rem,
  input  logic `DU s,
  input  logic `DU t,
  output logic     div_bsy,
  output logic `DU div_q,
  output logic `DU div_r,
  output logic `DU div_t_o,
  output logic     div_t_x,
  output logic     div_by0
);

  div_state_t state_q;
  logic [5:0] cnt_q;
  logic `DU   quo_q, den_q, rem_q;
  logic       neg_quo_q, neg_rem_q, op_rem_q;
  logic `DU   s_abs, t_abs, quo_d, rem_d, diff, q_fix, r_fix;
  logic       ge;

  // quo_q starts as |s| and is shifted out MSB first while quotient bits shift in
  always_comb begin
    s_abs = s[31] ? -s : s;
    t_abs = t[31] ? -t : t;
    ge    = {rem_q, quo_q[31]} >= {1'b0, den_q};
    diff  = {rem_q[30:0], quo_q[31]} - den_q;
    rem_d = ge ? diff : {rem_q[30:0], quo_q[31]};
    quo_d = {quo_q[30:0], ge};
    q_fix = neg_quo_q ? -quo_q : quo_q;
    r_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      op_rem_q  <= 1'b0;
      div_bsy   <= 1'b0;
      div_q     <= '0;
      div_r     <= '0;
      div_t_o   <= '0;
      div_t_x   <= 1'b0;
      div_by0   <= 1'b0;
    end else begin
      div_t_x <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_en) begin
            quo_q     <= s_abs;
            den_q     <= t_abs;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= s[31] ^ t[31];
            neg_rem_q <= s[31];
            op_rem_q  <= op_rem;
            div_bsy   <= 1'b1;
            state_q   <= CALC;
`ifdef EJ32_DIV_ZERO_CHK_EN
            div_by0 <= (t == '0);
            // zero quotient, |s| as remainder: the FIX sign rule then yields div_r = s
            if (t == '0) begin
              quo_q   <= '0;
              rem_q   <= s_abs;
              state_q <= FIX;
            end
`else
            div_by0 <= 1'b0;
`endif
          end
        end
        CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_STEPS - 1)) state_q <= FIX;
        end
        FIX: begin
          div_q   <= q_fix;
          div_r   <= r_fix;
          div_t_o <= op_rem_q ? r_fix : q_fix;
          div_t_x <= 1'b1;
          div_bsy <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ej32_div.md
EJ32_DIV -- requirements
Module: ej32_div

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: div_en  input  1  start request, sampled only in IDLE.
REQ-004 SHALL have port: op_rem  input  1  0 = idiv result on div_t_o, 1 = irem result on div_t_o; latched at start.
REQ-005 SHALL have port: s  input  32  dividend (NOS), signed.
REQ-006 SHALL have port: t  input  32  divisor (TOS), signed.
REQ-007 SHALL have port: div_bsy  output  1  high while a division is in progress.
REQ-008 SHALL have port: div_q  output  32  signed quotient.
REQ-009 SHALL have port: div_r  output  32  signed remainder.
REQ-010 SHALL have port: div_t_o  output  32  selected result for TOS arbitration.
REQ-011 SHALL have port: div_t_x  output  1  one-cycle TOS update strobe.
REQ-012 SHALL have port: div_by0  output  1  divide-by-zero flag.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX.
- IDLE->CALC on div_en=1.
- CALC->FIX after 32 iterations.
- FIX->IDLE unconditionally.
REQ-014 SHALL, on start, latch |s|, |t|, sign(s), sign(s)^sign(t) and op_rem, and clear the iteration counter.
REQ-015 SHALL perform unsigned restoring division in CALC, one quotient bit per cycle, MSB first; the counter is 6 bits, 0..31.
REQ-016 SHALL, in FIX:
- negate the quotient when sign(s)^sign(t)=1;
- negate the remainder when sign(s)=1;
- register div_q and div_r.
REQ-017 SHALL assert div_bsy from the cycle after the start cycle through the FIX cycle, i.e. 33 cycles for a normal divide.
REQ-018 SHALL pulse div_t_x for exactly one cycle, the cycle after FIX, with div_t_o = op_rem ? div_r : div_q.
REQ-019 SHALL hold div_q, div_r and div_t_o stable from that cycle until the next start.
REQ-020 SHALL ignore div_en while div_bsy=1; a running operation is never restarted or aborted except by reset.
REQ-021 SHALL follow Java semantics:
- the quotient truncates toward zero;
- the remainder takes the sign of the dividend;
- 0x80000000 / -1 = 0x80000000 with remainder 0, via 32-bit wrap of magnitude negation.
REQ-022 SHALL accept a new div_en in the same cycle that div_t_x is high, since the state is then IDLE.

Reset
REQ-023 SHALL, on rst=0 at any time including mid-CALC, immediately:
- enter IDLE;
- force div_bsy=0, div_t_x=0 and div_by0=0;
- force div_q, div_r and div_t_o to 0;
- clear the counter and working registers.
REQ-024 SHALL begin operation on the first rising clk edge after rst deasserts.

Configuration
REQ-025 SHALL, with EJ32_DIV_ZERO_CHK_EN defined, handle a zero divisor detected at start as follows:
- go directly to FIX, so div_bsy is high for 1 cycle;
- return div_q=0 and div_r=s;
- set div_by0=1, held until the next start.
REQ-026 SHALL, without EJ32_DIV_ZERO_CHK_EN, handle a zero divisor as follows:
- tie div_by0 to 0;
- run the full 32-cycle algorithm unchanged, giving quotient magnitude 0xFFFFFFFF and remainder magnitude |s| before sign fix.

Structure
REQ-027 SHALL take div_state_t (IDLE/CALC/FIX) and the constant DIV_STEPS=32 from ej32_pkg; data widths SHALL use the shared `DU width.
REQ-028 SHALL be a single module with no sub-module; the negators and the subtractor are inline.

Verification
REQ-029 SHALL cover: s=100, t=7, op_rem=0 -> div_bsy high 33 cycles, then div_t_x pulse, div_t_o=14, div_r=2.
REQ-030 SHALL cover: s=-100, t=7, op_rem=1 -> div_r=0xFFFFFFFE (-2), div_q=0xFFFFFFF2 (-14), div_t_o=0xFFFFFFFE.
REQ-031 SHALL cover: s=0x80000000, t=-1 -> div_q=0x80000000, div_r=0, no hang.
REQ-032 SHALL cover: s=7, t=0, in both builds.
- With the macro: div_bsy 1 cycle, div_q=0, div_r=7, div_by0=1.
- Without the macro: div_bsy 33 cycles, div_q=0xFFFFFFFF, div_r=7, div_by0=0.
REQ-033 SHALL cover: start 100/7, re-pulse div_en at cycle 5, assert rst=0 at cycle 10.
- The cycle-5 pulse is ignored.
- On reset, div_bsy drops at once and all outputs read 0.
- After release, 9/3 gives div_q=3.
REQ-034 SHALL cover back-to-back starts: div_en high in the div_t_x cycle of 20/4 -> second divide 21/4 starts without a gap, giving div_q=5 then div_q=5 with div_r=1.
